// File: rtl/mod_count_monitor_if.sv
// Count stream from an upstream mod-N counter into the sequence monitor,
// together with the monitor's status and statistics outputs.
interface mod_count_monitor_if #(
   parameter int W  = 3,
   parameter int CW = 8
);
   logic [W-1:0]  count_in;
   logic          count_valid;
   logic          stat_clr;
   logic          locked;
   logic          wrap_pulse;
   logic          err_pulse;
   logic          err_sticky;
   logic [CW-1:0] wrap_count;
   logic [CW-1:0] err_count;
   logic [W-1:0]  last_bad;

   // Counter / bench side: drives the count stream, observes status
   modport master (
      output count_in, count_valid, stat_clr,
      input  locked, wrap_pulse, err_pulse, err_sticky,
      input  wrap_count, err_count, last_bad
   );

   // Monitor side
   modport slave (
      input  count_in, count_valid, stat_clr,
      output locked, wrap_pulse, err_pulse, err_sticky,
      output wrap_count, err_count, last_bad
   );
endinterface

// File: rtl/mod_count_monitor.sv
// Sequence checker for a mod-MOD counter. Locks onto 0,1,..,MOD-1,0,.. after
// one full correct period, then flags every broken step and every out-of-range
// value, and keeps saturating wrap/error statistics.
module mod_count_monitor #(
   parameter int MOD = 7,
   parameter int W   = 3,
   parameter int CW  = 8
) (
   input  logic            clk,
   input  logic            rst,
   mod_count_monitor_if.slave mon
);

   // W+1 bits so MOD == 2**W is representable without overflow
   localparam logic [W:0] MOD_W  = (W+1)'(MOD);
   localparam logic [W:0] MOD_M1 = (W+1)'(MOD - 1);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [W-1:0]  prev, prev_n;
   logic [W-1:0]  acq_cnt, acq_cnt_n;
   logic          wrap_ev, err_ev;

   logic          locked_r, wrap_pulse_r, err_pulse_r, err_sticky_r;
   logic [CW-1:0] wrap_count_r, err_count_r;
   logic [W-1:0]  last_bad_r;

   // Successor in the count sequence, wrapping at MOD-1
   function automatic logic [W-1:0] succ(input logic [W-1:0] v);
      if ({1'b0, v} == MOD_M1) return '0;
      else                     return v + 1'b1;
   endfunction

   // Saturating increment for the statistics counters
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      if (&c) return c;
      else    return c + 1'b1;
   endfunction

   // Statistics update: stat_clr wins over the old value but never over a new event
   function automatic logic [CW-1:0] stat_next(input logic [CW-1:0] c,
                                               input logic clr, input logic ev);
      if (clr)     return ev ? {{(CW-1){1'b0}}, 1'b1} : '0;
      else if (ev) return sat_inc(c);
      else         return c;
   endfunction

   // Next-state and event decode; nothing changes on cycles without count_valid
   always_comb begin
      logic [W-1:0] acq_inc;
      state_n   = state;
      prev_n    = prev;
      acq_cnt_n = acq_cnt;
      wrap_ev   = 1'b0;
      err_ev    = 1'b0;
      acq_inc   = acq_cnt + 1'b1;
      if (mon.count_valid) begin
         if ({1'b0, mon.count_in} >= MOD_W) begin
            err_ev  = 1'b1;
            state_n = SEARCH;
         end else begin
            case (state)
               SEARCH: begin
                  if (mon.count_in == '0) begin
                     state_n   = ACQUIRE;
                     prev_n    = '0;
                     acq_cnt_n = '0;
                  end
               end
               ACQUIRE: begin
                  if (mon.count_in == succ(prev)) begin
                     prev_n    = mon.count_in;
                     acq_cnt_n = acq_inc;
                     if ({1'b0, acq_inc} == MOD_M1) state_n = LOCKED;
                  end else begin
                     state_n = SEARCH;
                  end
               end
               LOCKED: begin
                  if (mon.count_in == succ(prev)) begin
                     prev_n  = mon.count_in;
                     wrap_ev = ({1'b0, prev} == MOD_M1);
                  end else begin
                     err_ev  = 1'b1;
                     state_n = SEARCH;
                  end
               end
               default: state_n = SEARCH;
            endcase
         end
      end
   end

   // Tracking state: FSM, last accepted value and acquisition progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= SEARCH;
         prev    <= '0;
         acq_cnt <= '0;
      end else begin
         state   <= state_n;
         prev    <= prev_n;
         acq_cnt <= acq_cnt_n;
      end
   end

   // Registered status pulses, sticky flag, statistics and captured bad value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         locked_r     <= 1'b0;
         wrap_pulse_r <= 1'b0;
         err_pulse_r  <= 1'b0;
         err_sticky_r <= 1'b0;
         wrap_count_r <= '0;
         err_count_r  <= '0;
         last_bad_r   <= '0;
      end else begin
         locked_r     <= (state_n == LOCKED);
         wrap_pulse_r <= wrap_ev;
         err_pulse_r  <= err_ev;
         err_sticky_r <= mon.stat_clr ? err_ev : (err_sticky_r | err_ev);
         wrap_count_r <= stat_next(wrap_count_r, mon.stat_clr, wrap_ev);
         err_count_r  <= stat_next(err_count_r, mon.stat_clr, err_ev);
         if (err_ev) last_bad_r <= mon.count_in;
      end
   end

   assign mon.locked     = locked_r;
   assign mon.wrap_pulse = wrap_pulse_r;
   assign mon.err_pulse  = err_pulse_r;
   assign mon.err_sticky = err_sticky_r;
   assign mon.wrap_count = wrap_count_r;
   assign mon.err_count  = err_count_r;
   assign mon.last_bad   = last_bad_r;

endmodule

// File: tb/tb_mod_count_monitor.sv
// Directed bench for mod_count_monitor: a mod-7 instance with 8-bit statistics
// and a second mod-7 instance with 3-bit statistics for saturation.
module tb_mod_count_monitor;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   mod_count_monitor_if #(.W(3), .CW(8)) m1 ();
   mod_count_monitor_if #(.W(3), .CW(3)) m2 ();

   mod_count_monitor #(.MOD(7), .W(3), .CW(8)) dut1 (
      .clk (clk),
      .rst (rst),
      .mon (m1.slave)
   );

   mod_count_monitor #(.MOD(7), .W(3), .CW(3)) dut2 (
      .clk (clk),
      .rst (rst),
      .mon (m2.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Present one sample to the first monitor and return just after the edge
   task automatic tick1(input logic [2:0] v, input logic vld, input logic clr);
      m1.count_in    = v;
      m1.count_valid = vld;
      m1.stat_clr    = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic tick2(input logic [2:0] v, input logic vld);
      m2.count_in    = v;
      m2.count_valid = vld;
      m2.stat_clr    = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      m1.count_in = '0; m1.count_valid = 1'b0; m1.stat_clr = 1'b0;
      m2.count_in = '0; m2.count_valid = 1'b0; m2.stat_clr = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_locked",     m1.locked,     0);
      chk("rst_wrap_pulse", m1.wrap_pulse, 0);
      chk("rst_err_pulse",  m1.err_pulse,  0);
      chk("rst_err_sticky", m1.err_sticky, 0);
      chk("rst_wrap_count", m1.wrap_count, 0);
      chk("rst_err_count",  m1.err_count,  0);
      chk("rst_last_bad",   m1.last_bad,   0);
      chk("rst2_err_count", m2.err_count,  0);
      @(negedge clk);
      rst = 1'b0;

      // Free-running counter: lock after 0 plus 6 steps, wrap every 7 samples
      for (int i = 0; i <= 72; i++) begin
         tick1(3'(i % 7), 1'b1, 1'b0);
         chk($sformatf("run_locked_%0d", i), m1.locked, (i >= 6) ? 1 : 0);
         chk($sformatf("run_wrap_%0d", i), m1.wrap_pulse,
             (i >= 7 && (i % 7) == 0) ? 1 : 0);
         chk($sformatf("run_err_%0d", i), m1.err_pulse, 0);
      end
      chk("run_wrap_count", m1.wrap_count, 10);
      chk("run_err_count",  m1.err_count,  0);

      // Stalled counter: count_valid low, junk on count_in is ignored
      for (int i = 0; i < 5; i++) begin
         tick1(3'd6, 1'b0, 1'b0);
         chk($sformatf("stall_locked_%0d", i), m1.locked,     1);
         chk($sformatf("stall_wrap_%0d", i),   m1.wrap_pulse, 0);
         chk($sformatf("stall_err_%0d", i),    m1.err_pulse,  0);
      end
      tick1(3'd3, 1'b1, 1'b0);
      chk("resume_locked", m1.locked,    1);
      chk("resume_err",    m1.err_pulse, 0);

      // Sequence error 3 -> 5 while locked
      tick1(3'd5, 1'b1, 1'b0);
      chk("seq_err_pulse",  m1.err_pulse,  1);
      chk("seq_last_bad",   m1.last_bad,   5);
      chk("seq_err_sticky", m1.err_sticky, 1);
      chk("seq_locked",     m1.locked,     0);
      chk("seq_err_count",  m1.err_count,  1);
      tick1(3'd6, 1'b1, 1'b0);
      chk("seq_err_once",   m1.err_pulse,  0);
      chk("seq_sticky_hold", m1.err_sticky, 1);

      // Re-lock after the next 0 plus 6 correct steps
      for (int i = 0; i <= 6; i++) begin
         tick1(3'(i), 1'b1, 1'b0);
         chk($sformatf("relock_%0d", i), m1.locked, (i == 6) ? 1 : 0);
      end
      tick1(3'd0, 1'b1, 1'b0);
      chk("relock_wrap",       m1.wrap_pulse, 1);
      chk("relock_wrap_count", m1.wrap_count, 11);

      // Upstream reset mid-period (2 -> 0) counts as an error
      tick1(3'd1, 1'b1, 1'b0);
      tick1(3'd2, 1'b1, 1'b0);
      tick1(3'd0, 1'b1, 1'b0);
      chk("midrst_err_pulse", m1.err_pulse, 1);
      chk("midrst_last_bad",  m1.last_bad,  0);
      chk("midrst_err_count", m1.err_count, 2);
      chk("midrst_locked",    m1.locked,    0);

      // Out-of-range value in SEARCH
      tick1(3'd7, 1'b1, 1'b0);
      chk("range_err_pulse", m1.err_pulse, 1);
      chk("range_err_count", m1.err_count, 3);
      chk("range_last_bad",  m1.last_bad,  7);
      chk("range_locked",    m1.locked,    0);
      tick1(3'd1, 1'b1, 1'b0);
      chk("range_still_search", m1.err_pulse, 0);
      chk("range_count_hold",   m1.err_count, 3);

      // stat_clr together with an error keeps the new event
      tick1(3'd7, 1'b1, 1'b1);
      chk("clr_ev_err_count",  m1.err_count,  1);
      chk("clr_ev_err_sticky", m1.err_sticky, 1);
      chk("clr_ev_wrap_count", m1.wrap_count, 0);
      chk("clr_ev_err_pulse",  m1.err_pulse,  1);
      tick1(3'd3, 1'b1, 1'b1);
      chk("clr_err_count",  m1.err_count,  0);
      chk("clr_err_sticky", m1.err_sticky, 0);

      // Lock again, then pulse rst between edges
      for (int i = 0; i <= 6; i++) tick1(3'(i), 1'b1, 1'b0);
      chk("pre_rst_locked", m1.locked, 1);
      tick1(3'd0, 1'b1, 1'b0);
      chk("pre_rst_wrap",       m1.wrap_pulse, 1);
      chk("pre_rst_wrap_count", m1.wrap_count, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_locked",     m1.locked,     0);
      chk("async_wrap_pulse", m1.wrap_pulse, 0);
      chk("async_wrap_count", m1.wrap_count, 0);
      chk("async_err_sticky", m1.err_sticky, 0);
      #2 rst = 1'b0;

      // After release: no pulse and no lock until 0 plus 6 correct steps
      for (int i = 0; i < 14; i++) begin
         tick1(3'((i + 1) % 7), 1'b1, 1'b0);
         chk($sformatf("post_locked_%0d", i), m1.locked, (i >= 12) ? 1 : 0);
         chk($sformatf("post_wrap_%0d", i), m1.wrap_pulse, (i == 13) ? 1 : 0);
         chk($sformatf("post_err_%0d", i),  m1.err_pulse, 0);
      end

      // 3-bit statistics saturate at 7 after 9 errors
      for (int k = 1; k <= 9; k++) begin
         tick2(3'd7, 1'b1);
         chk($sformatf("sat_err_count_%0d", k), m2.err_count, (k > 7) ? 7 : k);
         chk($sformatf("sat_err_pulse_%0d", k), m2.err_pulse, 1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
